// File: rtl/frontend_sweep_controller_if.sv
// Result record channel from the sweep controller to its downstream consumer.
// Valid/ready handshake; the record is held stable while VALID=1 and READY=0.
interface frontend_sweep_controller_if #(
   parameter int PHASE_INCREMENT_BITS = 28,
   parameter int RESULT_MUL_ACC_WIDTH = 36,
   parameter int POINT_COUNT_BITS     = 12
);
   logic                            RESULT_VALID;
   logic                            RESULT_READY;
   logic [PHASE_INCREMENT_BITS-1:0] RESULT_PHASE_INC;
   logic [POINT_COUNT_BITS-1:0]     RESULT_INDEX;
   logic [RESULT_MUL_ACC_WIDTH-1:0] RESULT_SIN;
   logic [RESULT_MUL_ACC_WIDTH-1:0] RESULT_COS;

   modport master (
      output RESULT_VALID, RESULT_PHASE_INC, RESULT_INDEX, RESULT_SIN, RESULT_COS,
      input  RESULT_READY
   );
   modport slave (
      input  RESULT_VALID, RESULT_PHASE_INC, RESULT_INDEX, RESULT_SIN, RESULT_COS,
      output RESULT_READY
   );
endinterface

// File: rtl/frontend_sweep_controller.sv
// Steps the frontend DCO phase increment through N points, waits a settle time after
// each write, then snapshots SIN/COS accumulators into a valid/ready result record.
module frontend_sweep_controller #(
   parameter int PHASE_INCREMENT_BITS = 28,
   parameter int RESULT_MUL_ACC_WIDTH = 36,
   parameter int POINT_COUNT_BITS     = 12,
   parameter int SETTLE_BITS          = 16
) (
   input  logic                            CLK,
   input  logic                            RESET_N,
   input  logic                            CE,
   input  logic                            START,
   input  logic                            ABORT,
   input  logic [PHASE_INCREMENT_BITS-1:0] START_PHASE_INC,
   input  logic [PHASE_INCREMENT_BITS-1:0] STEP_PHASE_INC,
   input  logic [POINT_COUNT_BITS-1:0]     POINT_COUNT,
   input  logic [SETTLE_BITS-1:0]          SETTLE_CYCLES,
   input  logic [RESULT_MUL_ACC_WIDTH-1:0] SIN_MUL_ACC,
   input  logic [RESULT_MUL_ACC_WIDTH-1:0] COS_MUL_ACC,
   output logic [PHASE_INCREMENT_BITS-1:0] PHASE_INCREMENT_OUT,
   output logic                            PHASE_INCREMENT_WE,
   output logic                            BUSY,
   output logic                            DONE,
   frontend_sweep_controller_if.master     res
);
   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] PROGRAM    = 3'd1;
   localparam logic [2:0] SETTLE     = 3'd2;
   localparam logic [2:0] CAPTURE    = 3'd3;
   localparam logic [2:0] WAIT_READY = 3'd4;

   logic [2:0]                      state;
   logic [PHASE_INCREMENT_BITS-1:0] cur, step_l;
   logic [POINT_COUNT_BITS-1:0]     idx, count_l;
   logic [SETTLE_BITS-1:0]          settle_l, settle_cnt;
   logic [PHASE_INCREMENT_BITS-1:0] next_inc;

   assign next_inc = cur + step_l;
   // The output register is loaded on entry to PROGRAM so the strobe and value coincide.
   assign PHASE_INCREMENT_WE = (state == PROGRAM) && CE;
   assign BUSY = (state != IDLE);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state                <= IDLE;
         cur                  <= '0;
         step_l               <= '0;
         idx                  <= '0;
         count_l              <= '0;
         settle_l             <= '0;
         settle_cnt           <= '0;
         PHASE_INCREMENT_OUT  <= '0;
         DONE                 <= 1'b0;
         res.RESULT_VALID     <= 1'b0;
         res.RESULT_PHASE_INC <= '0;
         res.RESULT_INDEX     <= '0;
         res.RESULT_SIN       <= '0;
         res.RESULT_COS       <= '0;
      end else if (CE) begin
         DONE <= 1'b0;
         if (ABORT && state != IDLE) begin
            state            <= IDLE;
            res.RESULT_VALID <= 1'b0;
         end else begin
            case (state)
               IDLE: if (START) begin
                  step_l   <= STEP_PHASE_INC;
                  count_l  <= POINT_COUNT;
                  settle_l <= SETTLE_CYCLES;
                  cur      <= START_PHASE_INC;
                  idx      <= '0;
                  if (POINT_COUNT == '0) DONE <= 1'b1;
                  else begin
                     PHASE_INCREMENT_OUT <= START_PHASE_INC;
                     state               <= PROGRAM;
                  end
               end
               PROGRAM: begin
                  settle_cnt <= settle_l;
                  state      <= (settle_l == '0) ? CAPTURE : SETTLE;
               end
               SETTLE: begin
                  // Leaving on the count of 1 spends exactly settle_l cycles here.
                  if (settle_cnt <= SETTLE_BITS'(1)) begin
                     settle_cnt <= '0;
                     state      <= CAPTURE;
                  end else settle_cnt <= settle_cnt - SETTLE_BITS'(1);
               end
               CAPTURE: begin
                  res.RESULT_SIN       <= SIN_MUL_ACC;
                  res.RESULT_COS       <= COS_MUL_ACC;
                  res.RESULT_PHASE_INC <= cur;
                  res.RESULT_INDEX     <= idx;
                  res.RESULT_VALID     <= 1'b1;
                  state                <= WAIT_READY;
               end
               WAIT_READY: if (res.RESULT_READY) begin
                  res.RESULT_VALID <= 1'b0;
                  if (idx == count_l - POINT_COUNT_BITS'(1)) begin
                     DONE  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     cur                 <= next_inc;
                     PHASE_INCREMENT_OUT <= next_inc;
                     idx                 <= idx + POINT_COUNT_BITS'(1);
                     state               <= PROGRAM;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_frontend_sweep_controller.sv
// Scoreboard bench for frontend_sweep_controller: stimulus pushes expected WE values and
// result records; a negedge monitor pops and compares whenever the DUT presents them.
module tb_frontend_sweep_controller;
   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        CE = 1'b1;
   logic        START = 1'b0;
   logic        ABORT = 1'b0;
   logic [27:0] START_PHASE_INC = '0;
   logic [27:0] STEP_PHASE_INC = '0;
   logic [11:0] POINT_COUNT = '0;
   logic [15:0] SETTLE_CYCLES = '0;
   logic [35:0] SIN_MUL_ACC, COS_MUL_ACC;
   logic [27:0] PHASE_INCREMENT_OUT;
   logic        PHASE_INCREMENT_WE, BUSY, DONE;
   logic        rdy = 1'b1;
   bit          ce_tog = 1'b0;

   frontend_sweep_controller_if res_if ();
   assign res_if.RESULT_READY = rdy;

   frontend_sweep_controller dut (
      .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .START(START), .ABORT(ABORT),
      .START_PHASE_INC(START_PHASE_INC), .STEP_PHASE_INC(STEP_PHASE_INC),
      .POINT_COUNT(POINT_COUNT), .SETTLE_CYCLES(SETTLE_CYCLES),
      .SIN_MUL_ACC(SIN_MUL_ACC), .COS_MUL_ACC(COS_MUL_ACC),
      .PHASE_INCREMENT_OUT(PHASE_INCREMENT_OUT), .PHASE_INCREMENT_WE(PHASE_INCREMENT_WE),
      .BUSY(BUSY), .DONE(DONE), .res(res_if)
   );

   always #5 CLK = ~CLK;

   // Frontend stand-in: accumulators are a known function of the programmed increment.
   function automatic logic [35:0] f_sin(input logic [27:0] p);
      return 36'd0 - {8'd0, p};
   endfunction
   function automatic logic [35:0] f_cos(input logic [27:0] p);
      return {8'hA5, p};
   endfunction
   assign SIN_MUL_ACC = f_sin(PHASE_INCREMENT_OUT);
   assign COS_MUL_ACC = f_cos(PHASE_INCREMENT_OUT);

   always @(posedge CLK) begin
      #1;
      CE = ce_tog ? ~CE : 1'b1;
   end

   typedef struct {
      logic [27:0] ph;
      logic [11:0] idx;
      logic [35:0] s;
      logic [35:0] c;
      int          gap;
   } rec_t;

   logic [27:0] we_q[$];
   rec_t        rec_q[$];
   int errors = 0, checks = 0;
   int exp_done = 0, done_cnt = 0;
   int cyc = 0, last_we_cyc = 0;
   logic valid_prev = 1'b0, done_prev = 1'b0;

   // Monitor
   always @(negedge CLK) begin
      cyc++;
      if (RESET_N) begin
         if (PHASE_INCREMENT_WE) begin
            checks++;
            if (we_q.size() == 0) begin
               errors++; $display("FAIL we_unexpected value=%h", PHASE_INCREMENT_OUT);
            end else begin
               if (PHASE_INCREMENT_OUT !== we_q[0]) begin
                  errors++; $display("FAIL we_value got=%h exp=%h", PHASE_INCREMENT_OUT, we_q[0]);
               end
               void'(we_q.pop_front());
            end
            checks++;
            if (res_if.RESULT_VALID !== 1'b0) begin
               errors++; $display("FAIL we_during_valid valid=%b exp=0", res_if.RESULT_VALID);
            end
            last_we_cyc = cyc;
         end
         if (res_if.RESULT_VALID) begin
            checks++;
            if (rec_q.size() == 0) begin
               errors++; $display("FAIL rec_unexpected idx=%0d", res_if.RESULT_INDEX);
            end else begin
               if (!valid_prev && rec_q[0].gap >= 0) begin
                  checks++;
                  if (cyc - last_we_cyc != rec_q[0].gap) begin
                     errors++;
                     $display("FAIL valid_latency got=%0d exp=%0d", cyc - last_we_cyc, rec_q[0].gap);
                  end
               end
               if (res_if.RESULT_PHASE_INC !== rec_q[0].ph || res_if.RESULT_INDEX !== rec_q[0].idx ||
                   res_if.RESULT_SIN !== rec_q[0].s || res_if.RESULT_COS !== rec_q[0].c) begin
                  errors++;
                  $display("FAIL rec_fields got=%h/%0d/%h/%h exp=%h/%0d/%h/%h",
                           res_if.RESULT_PHASE_INC, res_if.RESULT_INDEX, res_if.RESULT_SIN,
                           res_if.RESULT_COS, rec_q[0].ph, rec_q[0].idx, rec_q[0].s, rec_q[0].c);
               end
               if (rdy && CE) void'(rec_q.pop_front());
            end
         end
         if (DONE && !done_prev) done_cnt++;
      end
      valid_prev = res_if.RESULT_VALID;
      done_prev  = DONE;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++; $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic push_exp(input logic [27:0] st, input logic [27:0] stp, input int n,
                           input int stl, input bit gap_en, input int n_rec);
      logic [27:0] p = st;
      for (int i = 0; i < n; i++) begin
         we_q.push_back(p);
         if (i < n_rec) rec_q.push_back('{p, 12'(i), f_sin(p), f_cos(p), gap_en ? stl + 2 : -1});
         p = p + stp;
      end
   endtask

   task automatic start_sweep(input logic [27:0] st, input logic [27:0] stp,
                              input int n, input int stl);
      bit samp;
      START_PHASE_INC = st; STEP_PHASE_INC = stp;
      POINT_COUNT = 12'(n); SETTLE_CYCLES = 16'(stl);
      START = 1'b1;
      do begin
         samp = CE;
         @(posedge CLK); #1;
      end while (!samp);
      START = 1'b0;
      START_PHASE_INC = 28'h5A5A5A5; STEP_PHASE_INC = 28'h1234567;
      POINT_COUNT = 12'd7; SETTLE_CYCLES = 16'd99;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (BUSY && n < 3000) begin
         @(posedge CLK); #1; n++;
      end
      if (BUSY) begin
         errors++; checks++; $display("FAIL %s_timeout busy=1 exp=0", name);
      end
      @(negedge CLK); @(negedge CLK);
      chk({name, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
   endtask

   task automatic wait_we(input int k);
      for (int j = 0; j < k; j++) begin
         int n = 0;
         do begin @(negedge CLK); n++; end while (!PHASE_INCREMENT_WE && n < 500);
         if (!PHASE_INCREMENT_WE) begin errors++; checks++; $display("FAIL wait_we timeout we=0 exp=1"); end
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!res_if.RESULT_VALID && n < 500) begin @(posedge CLK); #1; n++; end
      if (!res_if.RESULT_VALID) begin errors++; checks++; $display("FAIL wait_valid timeout valid=0 exp=1"); end
   endtask

   initial begin
      #23;
      chk("reset_outs", {PHASE_INCREMENT_OUT, PHASE_INCREMENT_WE, BUSY, DONE, res_if.RESULT_VALID,
                         res_if.RESULT_INDEX}, 64'd0);
      chk("reset_data", {res_if.RESULT_SIN[27:0], res_if.RESULT_PHASE_INC}, 64'd0);
      @(posedge CLK); #1 RESET_N = 1'b1;
      @(posedge CLK); #1;

      // 1: basic three-point sweep
      push_exp(28'd109377165, 28'd1000000, 3, 10, 1, 3); exp_done++;
      start_sweep(28'd109377165, 28'd1000000, 3, 10);
      chk("t1_busy", BUSY, 1);
      wait_idle("t1");

      // 2: backpressure on point 1
      push_exp(28'd109377165, 28'd1000000, 3, 10, 1, 3); exp_done++;
      start_sweep(28'd109377165, 28'd1000000, 3, 10);
      wait_we(2);
      rdy = 1'b0;
      wait_valid();
      chk("t2_idx_held", res_if.RESULT_INDEX, 1);
      repeat (20) @(posedge CLK);
      #1 chk("t2_still_valid", res_if.RESULT_VALID, 1);
      rdy = 1'b1;
      wait_idle("t2");

      // 3: wrap of the phase increment, zero settle
      push_exp(28'hFFFFFF0, 28'h20, 2, 0, 1, 2); exp_done++;
      start_sweep(28'hFFFFFF0, 28'h20, 2, 0);
      wait_idle("t3");

      // 4: abort in the fifth settle cycle of point 1, then restart
      push_exp(28'h1000000, 28'h0000100, 2, 10, 1, 1);
      start_sweep(28'h1000000, 28'h0000100, 3, 10);
      wait_we(2);
      @(posedge CLK); repeat (4) @(posedge CLK);
      #1 ABORT = 1'b1;
      @(posedge CLK); #1 ABORT = 1'b0;
      chk("t4_busy", BUSY, 0);
      chk("t4_valid", res_if.RESULT_VALID, 0);
      chk("t4_pinc_hold", PHASE_INCREMENT_OUT, 28'h1000100);
      repeat (20) @(posedge CLK);
      #1 chk("t4_pinc_hold2", PHASE_INCREMENT_OUT, 28'h1000100);
      @(negedge CLK);
      chk("t4_no_done", done_cnt, exp_done);
      ABORT = 1'b1; @(posedge CLK); #1 ABORT = 1'b0;
      chk("t4_abort_idle_ignored", BUSY, 0);
      push_exp(28'h2000000, 28'h10, 1, 3, 1, 1); exp_done++;
      start_sweep(28'h2000000, 28'h10, 1, 3);
      wait_idle("t4r");

      // 5a: empty sweep
      exp_done++;
      start_sweep(28'h0ABCDEF, 28'h1, 0, 5);
      chk("t5_done", DONE, 1);
      chk("t5_busy", BUSY, 0);
      @(negedge CLK);
      chk("t5_pinc_unchanged", PHASE_INCREMENT_OUT, 28'h2000000);
      wait_idle("t5a");

      // 5b: case 1 under alternating CE
      ce_tog = 1'b1;
      push_exp(28'd109377165, 28'd1000000, 3, 10, 0, 3); exp_done++;
      start_sweep(28'd109377165, 28'd1000000, 3, 10);
      wait_idle("t5b");
      ce_tog = 1'b0;
      @(posedge CLK); #1;

      // 6: reset while a record waits for READY
      rdy = 1'b0;
      push_exp(28'h0300000, 28'h1000, 1, 3, 1, 1);
      start_sweep(28'h0300000, 28'h1000, 2, 3);
      wait_valid();
      repeat (3) @(posedge CLK);
      #2 RESET_N = 1'b0;
      #1;
      chk("t6_rst_outs", {PHASE_INCREMENT_OUT, PHASE_INCREMENT_WE, BUSY, DONE, res_if.RESULT_VALID,
                          res_if.RESULT_INDEX}, 64'd0);
      chk("t6_rst_data", {res_if.RESULT_SIN[27:0], res_if.RESULT_COS[35:28],
                          res_if.RESULT_PHASE_INC}, 64'd0);
      rec_q.delete();
      @(posedge CLK); #1 RESET_N = 1'b1; rdy = 1'b1;
      push_exp(28'h0400000, 28'h2000, 2, 4, 1, 2); exp_done++;
      start_sweep(28'h0400000, 28'h2000, 2, 4);
      wait_idle("t6");

      chk("we_q_empty", we_q.size(), 0);
      chk("rec_q_empty", rec_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout time exceeded");
      $fatal(1, "timeout");
   end
endmodule
